// File: rtl/pipeline_run_pkg.sv
// Shared encodings for the pipeline run/step/halt sequencer: FSM states,
// host command opcodes, halt causes and the default halt instruction opcode.
package pipeline_run_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RUN    = 3'd1,
      ST_STEP   = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_HALTED = 3'd4
   } run_state_t;

   localparam logic [1:0] OP_NONE = 2'b00;
   localparam logic [1:0] OP_RUN  = 2'b01;
   localparam logic [1:0] OP_STEP = 2'b10;
   localparam logic [1:0] OP_HALT = 2'b11;

   localparam logic [1:0] CAUSE_NONE      = 2'd0;
   localparam logic [1:0] CAUSE_CMD       = 2'd1;
   localparam logic [1:0] CAUSE_BP        = 2'd2;
   localparam logic [1:0] CAUSE_HALT_INSN = 2'd3;

   localparam logic [5:0] DEFAULT_HALT_OPCODE = 6'h3F;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with enable and synchronous clear that holds at all-ones
// instead of wrapping.
module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk) begin
      if (reset)
         count <= '0;
      else if (en && (count != '1))
         count <= count + WIDTH'(1);
   end

endmodule

// File: rtl/pipeline_run_control.sv
// Run/step/halt sequencer producing the global enable for the 5-stage MIPS
// pipeline; halts on host command, PC breakpoint or a halt opcode in ID.
module pipeline_run_control
   import pipeline_run_pkg::*;
#(
   parameter int         CNT_WIDTH    = 32,
   parameter logic [5:0] HALT_OPCODE  = DEFAULT_HALT_OPCODE,
   parameter int         DRAIN_CYCLES = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cmd_valid,
   input  logic [1:0]           cmd_op,
   output logic                 cmd_ready,
   input  logic                 bp_enable,
   input  logic [31:0]          bp_addr,
   input  logic [31:0]          pc_IF,
   input  logic [31:0]          instruction_ID,
   output logic                 pipe_enable,
   output logic                 fetch_hold,
   output logic                 halted,
   output logic [1:0]           halt_cause,
   output logic                 step_done,
   output logic [2:0]           state,
   output logic [CNT_WIDTH-1:0] cycle_count
);

   localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(DRAIN_CYCLES - 1);

   run_state_t         state_r, state_nxt;
   logic [DRAIN_W-1:0] drain_cnt, drain_nxt;
   logic               bp_skip, skip_nxt;
   logic [1:0]         cause_nxt;
   logic               step_done_nxt;
   logic               bp_match, halt_insn, cmd_accept;
   logic               unused_insn_bits;

   assign unused_insn_bits = ^instruction_ID[25:0];

   // The compare is combinational so the matching fetch is suppressed in the same cycle.
   assign bp_match   = bp_enable && (pc_IF == bp_addr) && !bp_skip;
   assign halt_insn  = (instruction_ID[31:26] == HALT_OPCODE);
   assign cmd_ready  = (state_r == ST_IDLE) || (state_r == ST_RUN) || (state_r == ST_HALTED);
   assign cmd_accept = cmd_valid && cmd_ready;
   assign state      = state_r;

   always_comb begin
      pipe_enable = 1'b0;
      fetch_hold  = 1'b0;
      case (state_r)
         ST_RUN:   pipe_enable = !bp_match;
         ST_STEP:  pipe_enable = 1'b1;
         ST_DRAIN: begin
            pipe_enable = 1'b1;
            fetch_hold  = 1'b1;
         end
         default:  ;
      endcase
   end

   always_comb begin
      state_nxt     = state_r;
      drain_nxt     = drain_cnt;
      cause_nxt     = halt_cause;
      skip_nxt      = bp_skip && !pipe_enable;
      step_done_nxt = 1'b0;
      case (state_r)
         ST_IDLE, ST_HALTED: begin
            if (cmd_accept) begin
               case (cmd_op)
                  OP_RUN, OP_STEP: begin
                     state_nxt = (cmd_op == OP_RUN) ? ST_RUN : ST_STEP;
                     cause_nxt = CAUSE_NONE;
                     // Resuming from a breakpoint must not re-trigger on the same PC.
                     skip_nxt  = (state_r == ST_HALTED) && (halt_cause == CAUSE_BP);
                  end
                  OP_HALT: cause_nxt = CAUSE_CMD;
                  default: ;
               endcase
            end
         end
         ST_RUN: begin
            if (bp_match) begin
               state_nxt = ST_HALTED;
               cause_nxt = CAUSE_BP;
            end else if (halt_insn) begin
               state_nxt = ST_DRAIN;
               drain_nxt = DRAIN_INIT;
            end else if (cmd_accept && (cmd_op == OP_HALT)) begin
               state_nxt = ST_HALTED;
               cause_nxt = CAUSE_CMD;
            end
         end
         ST_STEP: begin
            if (halt_insn) begin
               state_nxt = ST_DRAIN;
               drain_nxt = DRAIN_INIT;
            end else begin
               state_nxt     = ST_HALTED;
               cause_nxt     = CAUSE_CMD;
               step_done_nxt = 1'b1;
            end
         end
         ST_DRAIN: begin
            if (drain_cnt == '0) begin
               state_nxt = ST_HALTED;
               cause_nxt = CAUSE_HALT_INSN;
            end else begin
               drain_nxt = drain_cnt - DRAIN_W'(1);
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         drain_cnt  <= '0;
         bp_skip    <= 1'b0;
         halt_cause <= CAUSE_NONE;
         halted     <= 1'b0;
         step_done  <= 1'b0;
      end else begin
         state_r    <= state_nxt;
         drain_cnt  <= drain_nxt;
         bp_skip    <= skip_nxt;
         halt_cause <= cause_nxt;
         halted     <= (state_nxt == ST_HALTED);
         step_done  <= step_done_nxt;
      end
   end

   sat_counter #(
      .WIDTH (CNT_WIDTH)
   ) u_cycle_count (
      .clk   (clk),
      .reset (reset),
      .en    (pipe_enable),
      .count (cycle_count)
   );

endmodule

// File: tb/tb_pipeline_run_control.sv
// Scoreboard bench for pipeline_run_control: a cycle model pushes expected
// outputs per driven cycle, popped and compared at the following negedge.
module tb_pipeline_run_control;
   import pipeline_run_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic [1:0]  cmd_op;
   logic        bp_enable;
   logic [31:0] bp_addr;
   logic [31:0] pc_IF;
   logic [31:0] instruction_ID;

   logic        cmd_ready, pipe_enable, fetch_hold, halted, step_done;
   logic [1:0]  halt_cause;
   logic [2:0]  state;
   logic [31:0] cycle_count;

   logic        s_cmd_ready, s_pipe_enable, s_fetch_hold, s_halted, s_step_done;
   logic [1:0]  s_halt_cause;
   logic [2:0]  s_state;
   logic [3:0]  s_cycle_count;

   always #5 clk = ~clk;

   pipeline_run_control #(.CNT_WIDTH(32), .HALT_OPCODE(6'h3F), .DRAIN_CYCLES(4)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
      .bp_enable(bp_enable), .bp_addr(bp_addr), .pc_IF(pc_IF), .instruction_ID(instruction_ID),
      .pipe_enable(pipe_enable), .fetch_hold(fetch_hold), .halted(halted), .halt_cause(halt_cause),
      .step_done(step_done), .state(state), .cycle_count(cycle_count));

   pipeline_run_control #(.CNT_WIDTH(4), .HALT_OPCODE(6'h3F), .DRAIN_CYCLES(4)) dut_sat (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(s_cmd_ready),
      .bp_enable(bp_enable), .bp_addr(bp_addr), .pc_IF(pc_IF), .instruction_ID(instruction_ID),
      .pipe_enable(s_pipe_enable), .fetch_hold(s_fetch_hold), .halted(s_halted),
      .halt_cause(s_halt_cause), .step_done(s_step_done), .state(s_state),
      .cycle_count(s_cycle_count));

   typedef struct {
      logic       pe, fh, rdy, hlt, sd;
      logic [1:0] cause;
      logic [2:0] st;
      longint     cnt;
   } exp_t;

   exp_t sb[$];

   int n_checks = 0;
   int n_fail   = 0;

   // model state
   logic [2:0]  m_st;
   logic [1:0]  m_cause;
   logic        m_hlt, m_sd, m_skip;
   int          m_drain;
   longint      m_cnt;
   logic [31:0] pc_reg;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      m_st = 3'd0; m_cause = 2'd0; m_hlt = 1'b0; m_sd = 1'b0;
      m_skip = 1'b0; m_drain = 0; m_cnt = 0;
   endtask

   // One clock cycle: drive, predict, compare at negedge, advance model at posedge.
   task automatic tick(input logic v, input logic [1:0] op);
      exp_t   e;
      logic   match, acc, hop;
      logic [2:0] nst;
      logic [1:0] ncause;
      logic   nsd, nskip;
      cmd_valid = v;
      cmd_op    = op;
      pc_IF     = pc_reg;
      match = bp_enable && (pc_reg == bp_addr) && !m_skip;
      hop   = (instruction_ID[31:26] == 6'h3F);
      e.rdy = (m_st == 3'd0) || (m_st == 3'd1) || (m_st == 3'd4);
      e.pe  = ((m_st == 3'd1) && !match) || (m_st == 3'd2) || (m_st == 3'd3);
      e.fh  = (m_st == 3'd3);
      e.hlt = m_hlt; e.sd = m_sd; e.cause = m_cause; e.st = m_st; e.cnt = m_cnt;
      sb.push_back(e);

      @(negedge clk);
      e = sb.pop_front();
      check_eq("pipe_enable", 64'(pipe_enable), 64'(e.pe));
      check_eq("fetch_hold",  64'(fetch_hold),  64'(e.fh));
      check_eq("cmd_ready",   64'(cmd_ready),   64'(e.rdy));
      check_eq("halted",      64'(halted),      64'(e.hlt));
      check_eq("halt_cause",  64'(halt_cause),  64'(e.cause));
      check_eq("step_done",   64'(step_done),   64'(e.sd));
      check_eq("state",       64'(state),       64'(e.st));
      check_eq("cycle_count", 64'(cycle_count), 64'(e.cnt));
      check_eq("sat_count",   64'(s_cycle_count), (e.cnt > 15) ? 64'd15 : 64'(e.cnt));
      check_eq("sat_pipe_en", 64'(s_pipe_enable), 64'(e.pe));

      @(posedge clk);
      if (reset) begin
         model_reset();
      end else begin
         acc = v && e.rdy;
         nst = m_st; ncause = m_cause; nsd = 1'b0;
         nskip = e.pe ? 1'b0 : m_skip;
         if (e.pe) m_cnt++;
         if (m_st == 3'd0 || m_st == 3'd4) begin
            if (acc && (op == 2'b01 || op == 2'b10)) begin
               nst = (op == 2'b01) ? 3'd1 : 3'd2;
               ncause = 2'd0;
               nskip = (m_st == 3'd4) && (m_cause == 2'd2);
            end else if (acc && op == 2'b11) begin
               ncause = 2'd1;
            end
         end else if (m_st == 3'd1) begin
            if (match) begin nst = 3'd4; ncause = 2'd2; end
            else if (hop) begin nst = 3'd3; m_drain = 3; end
            else if (acc && op == 2'b11) begin nst = 3'd4; ncause = 2'd1; end
         end else if (m_st == 3'd2) begin
            if (hop) begin nst = 3'd3; m_drain = 3; end
            else begin nst = 3'd4; ncause = 2'd1; nsd = 1'b1; end
         end else if (m_st == 3'd3) begin
            if (m_drain == 0) begin nst = 3'd4; ncause = 2'd3; end
            else m_drain--;
         end
         m_st = nst; m_cause = ncause; m_sd = nsd; m_skip = nskip;
         m_hlt = (nst == 3'd4);
         if (e.pe) pc_reg += 32'd4;
      end
      #1;
   endtask

   initial begin
      reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00;
      bp_enable = 1'b0; bp_addr = 32'h0; instruction_ID = 32'h0;
      pc_reg = 32'h0; pc_IF = 32'h0;
      model_reset();
      @(posedge clk); #1;

      // reset beats a simultaneous RUN command
      tick(1'b1, OP_RUN);
      tick(1'b1, OP_RUN);
      reset = 1'b0;
      tick(1'b0, OP_NONE);
      tick(1'b1, OP_RUN);
      repeat (5) tick(1'b0, OP_NONE);
      tick(1'b1, OP_HALT);
      check_eq("run_halt_cause", 64'(halt_cause), 64'd1);
      check_eq("run_count", 64'(cycle_count), 64'd6);

      // single step from HALTED
      tick(1'b1, OP_STEP);
      tick(1'b0, OP_NONE);
      check_eq("step_pulse", 64'(step_done), 64'd1);
      check_eq("step_count", 64'(cycle_count), 64'd7);
      tick(1'b0, OP_NONE);

      // breakpoint at 0x10, then resume past it
      pc_reg = 32'h0; bp_enable = 1'b1; bp_addr = 32'h10;
      tick(1'b1, OP_RUN);
      repeat (5) tick(1'b0, OP_NONE);
      check_eq("bp_cause", 64'(halt_cause), 64'd2);
      check_eq("bp_count", 64'(cycle_count), 64'd11);
      tick(1'b1, OP_RUN);
      repeat (3) tick(1'b0, OP_NONE);
      check_eq("bp_resume_state", 64'(state), 64'(ST_RUN));
      tick(1'b1, OP_HALT);
      bp_enable = 1'b0;

      // halt instruction drains for four enabled cycles; commands refused meanwhile
      tick(1'b1, OP_RUN);
      tick(1'b0, OP_NONE);
      instruction_ID = {6'h3F, 26'h0};
      tick(1'b0, OP_NONE);
      instruction_ID = 32'h0;
      tick(1'b1, OP_HALT);
      repeat (3) tick(1'b0, OP_NONE);
      check_eq("drain_cause", 64'(halt_cause), 64'd3);
      check_eq("drain_count", 64'(cycle_count), 64'd21);

      // halt opcode during STEP drains without step_done
      tick(1'b1, OP_STEP);
      instruction_ID = {6'h3F, 26'h155};
      tick(1'b0, OP_NONE);
      instruction_ID = 32'h0;
      repeat (4) tick(1'b0, OP_NONE);
      tick(1'b0, OP_NONE);

      // HALT command and breakpoint in the same cycle: breakpoint wins
      pc_reg = 32'h100; bp_enable = 1'b1; bp_addr = 32'h108;
      tick(1'b1, OP_RUN);
      tick(1'b0, OP_NONE);
      tick(1'b0, OP_NONE);
      tick(1'b1, OP_HALT);
      check_eq("bp_vs_cmd_cause", 64'(halt_cause), 64'd2);
      bp_enable = 1'b0;
      tick(1'b1, OP_HALT);
      tick(1'b1, OP_NONE);

      // long run saturates the narrow counter, then reset in the middle of a drain
      tick(1'b1, OP_RUN);
      repeat (20) tick(1'b0, OP_NONE);
      check_eq("sat_hold", 64'(s_cycle_count), 64'hF);
      instruction_ID = {6'h3F, 26'h0};
      tick(1'b0, OP_NONE);
      instruction_ID = 32'h0;
      tick(1'b0, OP_NONE);
      reset = 1'b1;
      tick(1'b1, OP_RUN);
      reset = 1'b0;
      check_eq("reset_drain_state", 64'(state), 64'(ST_IDLE));
      check_eq("reset_drain_count", 64'(cycle_count), 64'd0);
      repeat (3) tick(1'b0, OP_NONE);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipeline_run_control.md
Name: pipeline_run_control

Overview:
- Run/step/halt sequencer for the 5-stage MIPS pipeline.
- Drives a global pipeline enable that gates PC, IF_ID, ID_EX, EX_MEM, MEM_WB and register-file writes.
- Stops the core on host command, PC breakpoint, or a HALT instruction reaching ID. A halt instruction first drains older instructions to writeback.
- Sits beside the pipeline top; the host/debug interface issues commands through a valid/ready port.

Parameters:
- CNT_WIDTH, 32, width of the enabled-cycle counter.
- HALT_OPCODE, 6'h3F, opcode in instruction_ID[31:26] that requests halt.
- DRAIN_CYCLES, 4, enabled cycles after halt detection so older instructions complete WB (min 1).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  host command valid.
- cmd_op  in  2  00 none, 01 RUN, 10 STEP, 11 HALT.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- bp_enable  in  1  breakpoint compare enable.
- bp_addr  in  32  breakpoint PC.
- pc_IF  in  32  current PC in the IF stage.
- instruction_ID  in  32  instruction held in IF_ID.
- pipe_enable  out  1  1 = all pipeline state advances this cycle.
- fetch_hold  out  1  1 = PC_write low and IF_ID loads a NOP (drain).
- halted  out  1  1 while in HALTED.
- halt_cause  out  2  0 none, 1 command, 2 breakpoint, 3 halt instruction.
- step_done  out  1  one-cycle pulse when a STEP completes.
- state  out  3  encoded FSM state (debug).
- cycle_count  out  CNT_WIDTH  count of cycles with pipe_enable=1.

Behaviour:
- Reset:
  - state=IDLE; pipe_enable=0, fetch_hold=0, halted=0, halt_cause=0, step_done=0.
  - cycle_count=0; drain counter=0; bp_skip=0.
  - Reset wins over any same-cycle command.
  - Reset mid-RUN/DRAIN returns to IDLE on the next edge; no drain completes.
- States: IDLE, RUN, STEP, DRAIN, HALTED.
- cmd_ready:
  - 1 in IDLE, HALTED, RUN; 0 in STEP and DRAIN.
  - An accepted op 00 is a no-op.
  - In RUN, only HALT acts; RUN and STEP are accepted and ignored.
- IDLE/HALTED:
  - RUN -> RUN; STEP -> STEP; HALT -> stays put with halt_cause=1.
  - pipe_enable=0.
  - Leaving HALTED clears halt_cause and halted on the next edge.
- RUN:
  - pipe_enable=1 except on a breakpoint match.
  - Breakpoint match = bp_enable & pc_IF==bp_addr & !bp_skip. It is combinational: pipe_enable=0 in the match cycle, so the matching instruction is not fetched. Next state is HALTED with cause 2.
  - bp_skip is set on any RUN/STEP accept from HALTED with cause 2. It is cleared after the first enabled cycle, so resume proceeds past the breakpoint.
  - Accepted HALT: the accept cycle stays enabled; next state is HALTED with cause 1.
  - instruction_ID[31:26]==HALT_OPCODE while pipe_enable=1: next state is DRAIN with drain counter = DRAIN_CYCLES-1.
  - Priority: breakpoint > halt opcode > HALT command.
- STEP:
  - Exactly one cycle with pipe_enable=1.
  - Next state is HALTED (cause 1); step_done pulses in the first HALTED cycle.
  - Breakpoint ignored. A halt opcode seen during STEP goes to DRAIN instead and produces no step_done.
- DRAIN:
  - pipe_enable=1, fetch_hold=1.
  - Counter decrements each cycle. At 0, next state is HALTED with cause 3.
  - Commands are not accepted.
- cycle_count:
  - Increments in every cycle with pipe_enable=1.
  - Saturates at all-ones.
  - Cleared only by reset.
- Outputs halted, halt_cause, step_done, state are registered. pipe_enable and fetch_hold are decoded from state plus the breakpoint compare.

Decomposition:
- Shared package `pipeline_run_pkg`:
  - state encoding localparams (IDLE=0, RUN=1, STEP=2, DRAIN=3, HALTED=4).
  - cmd_op codes and halt_cause codes.
  - default HALT_OPCODE.
- One natural sub-module, `sat_counter` (parameterised width, enable, sync reset, saturate), for cycle_count; the drain counter stays inline.

Test Plan:
- Reset with cmd_valid=1, op=RUN -> IDLE, pipe_enable=0, cycle_count=0; after release, RUN accept -> pipe_enable=1 next cycle, count increments by 1 per cycle.
- From HALTED, STEP -> exactly one cycle pipe_enable=1, then halted=1, cause=1, step_done a single pulse, cycle_count +1.
- RUN with bp_enable=1, bp_addr=0x00000010 -> pipe_enable=0 in the cycle pc_IF=0x10, HALTED cause=2; then RUN -> PC advances past 0x10 without re-halting.
- RUN with instruction_ID opcode 0x3F, DRAIN_CYCLES=4 -> 4 cycles with pipe_enable=1 and fetch_hold=1, cmd_ready=0, then HALTED cause=3.
- HALT command accepted in RUN at the same cycle as a breakpoint match -> cause=2, pipe_enable=0 that cycle.
- CNT_WIDTH=4, run 20 cycles -> cycle_count holds at 4'hF; assert reset during DRAIN -> IDLE next cycle, count=0.
